// File: rtl/bf_prog_loader_pkg.sv
// Constants shared by the brainfuck core and its program loader.
package brainfuck_constants;
    // 3-bit opcode encoding of the eight brainfuck commands
    localparam logic [2:0] OP_INC_PTR = 3'd0;  // >
    localparam logic [2:0] OP_DEC_PTR = 3'd1;  // <
    localparam logic [2:0] OP_INC     = 3'd2;  // +
    localparam logic [2:0] OP_DEC     = 3'd3;  // -
    localparam logic [2:0] OP_OUT     = 3'd4;  // .
    localparam logic [2:0] OP_IN      = 3'd5;  // ,
    localparam logic [2:0] OP_JZ      = 3'd6;  // [
    localparam logic [2:0] OP_JNZ     = 3'd7;  // ]

    // Byte that terminates a program upload
    localparam logic [7:0] EOT_BYTE = 8'h04;

    typedef enum logic [1:0] {
        LOAD_WAIT,
        LOAD_ACK,
        RELEASE,
        RUN
    } loader_state_t;
endpackage

// File: rtl/bf_char_decode.sv
// ASCII brainfuck character to {valid, opcode}; everything else is not valid.
module bf_char_decode #(
    parameter int DATA_WIDTH      = 8,
    parameter int PROG_DATA_WIDTH = 3
) (
    input  logic [DATA_WIDTH-1:0]      ch,
    output logic                       valid,
    output logic [PROG_DATA_WIDTH-1:0] opcode
);
    import brainfuck_constants::*;

    // Pure lookup; unknown bytes (comments, whitespace) decode as invalid
    always_comb begin
        valid  = 1'b1;
        opcode = '0;
        case (ch)
            DATA_WIDTH'(8'h3E): opcode = PROG_DATA_WIDTH'(OP_INC_PTR);
            DATA_WIDTH'(8'h3C): opcode = PROG_DATA_WIDTH'(OP_DEC_PTR);
            DATA_WIDTH'(8'h2B): opcode = PROG_DATA_WIDTH'(OP_INC);
            DATA_WIDTH'(8'h2D): opcode = PROG_DATA_WIDTH'(OP_DEC);
            DATA_WIDTH'(8'h2E): opcode = PROG_DATA_WIDTH'(OP_OUT);
            DATA_WIDTH'(8'h2C): opcode = PROG_DATA_WIDTH'(OP_IN);
            DATA_WIDTH'(8'h5B): opcode = PROG_DATA_WIDTH'(OP_JZ);
            DATA_WIDTH'(8'h5D): opcode = PROG_DATA_WIDTH'(OP_JNZ);
            default:            valid  = 1'b0;
        endcase
    end
endmodule

// File: rtl/bf_prog_loader.sv
// Boot loader: owns UART RX and program memory until an EOT byte arrives,
// then hands both to the brainfuck core and releases it from reset.
module bf_prog_loader #(
    parameter int                    PROG_ADDR_WIDTH = 8,
    parameter int                    PROG_DATA_WIDTH = 3,
    parameter int                    DATA_WIDTH      = 8,
    parameter logic [DATA_WIDTH-1:0] EOT_CHAR        = DATA_WIDTH'(brainfuck_constants::EOT_BYTE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_req,
    input  logic [DATA_WIDTH-1:0]      rx_data,
    input  logic                       rx_ready,
    output logic                       rx_clear,
    output logic                       core_rx_ready,
    input  logic                       core_rx_clear,
    input  logic [PROG_ADDR_WIDTH-1:0] core_prog_addr,
    input  logic                       core_prog_rd_en,
    output logic [PROG_ADDR_WIDTH-1:0] prog_addr,
    output logic                       prog_rd_en,
    output logic                       prog_wr_en,
    output logic [PROG_DATA_WIDTH-1:0] prog_wr_data,
    output logic                       core_rst,
    output logic [PROG_ADDR_WIDTH:0]   prog_len,
    output logic                       loading,
    output logic                       overflow
);
    import brainfuck_constants::*;

    loader_state_t              state;
    logic [PROG_ADDR_WIDTH:0]   wr_ptr;     // one extra bit: MSB set means memory full
    logic                       rx_clear_q;
    logic                       load_req_d;
    logic                       load_edge;
    logic                       ch_valid;
    logic [PROG_DATA_WIDTH-1:0] ch_op;

    bf_char_decode #(
        .DATA_WIDTH      (DATA_WIDTH),
        .PROG_DATA_WIDTH (PROG_DATA_WIDTH)
    ) u_decode (
        .ch     (rx_data),
        .valid  (ch_valid),
        .opcode (ch_op)
    );

    assign load_edge = load_req & ~load_req_d;
    assign loading   = (state == LOAD_WAIT) || (state == LOAD_ACK);

    // Loader FSM. wr_ptr advances in LOAD_ACK so that during the write cycle
    // prog_addr (driven from wr_ptr) still points at the word being written.
    // core_rst drops one cycle after entering RUN, giving the core a full
    // idle cycle on the memory after the last write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= LOAD_WAIT;
            wr_ptr       <= '0;
            prog_len     <= '0;
            overflow     <= 1'b0;
            core_rst     <= 1'b1;
            rx_clear_q   <= 1'b0;
            prog_wr_en   <= 1'b0;
            prog_wr_data <= '0;
            load_req_d   <= 1'b0;
        end else begin
            load_req_d <= load_req;
            rx_clear_q <= 1'b0;
            prog_wr_en <= 1'b0;
            case (state)
                LOAD_WAIT: begin
                    core_rst <= 1'b1;
                    if (rx_ready) begin
                        rx_clear_q <= 1'b1;
                        state      <= LOAD_ACK;
                        if (rx_data == EOT_CHAR) begin
                            prog_len <= wr_ptr;
                            state    <= RELEASE;
                        end else if (ch_valid) begin
                            if (!wr_ptr[PROG_ADDR_WIDTH]) begin
                                prog_wr_en   <= 1'b1;
                                prog_wr_data <= ch_op;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                    end
                end
                LOAD_ACK: begin
                    if (prog_wr_en) wr_ptr <= wr_ptr + 1'b1;
                    state <= LOAD_WAIT;
                end
                RELEASE: begin
                    core_rst <= 1'b1;
                    state    <= RUN;
                end
                RUN: begin
                    if (load_edge) begin
                        state    <= LOAD_WAIT;
                        wr_ptr   <= '0;
                        overflow <= 1'b0;
                        core_rst <= 1'b1;
                    end else begin
                        core_rst <= 1'b0;
                    end
                end
                default: state <= LOAD_WAIT;
            endcase
        end
    end

    // Memory and UART arbitration: core owns both only in RUN
    always_comb begin
        prog_addr     = wr_ptr[PROG_ADDR_WIDTH-1:0];
        prog_rd_en    = 1'b0;
        core_rx_ready = 1'b0;
        rx_clear      = rx_clear_q;
        if (state == RUN) begin
            prog_addr     = core_prog_addr;
            prog_rd_en    = core_prog_rd_en;
            core_rx_ready = rx_ready;
            rx_clear      = core_rx_clear;
        end
    end
endmodule

// File: tb/tb_bf_prog_loader.sv
// Directed bench for bf_prog_loader: an 8-bit-address instance plus a
// 2-bit-address instance (depth 4) sharing the same input stream.
module tb_bf_prog_loader;
    logic       clk = 1'b0;
    logic       rst;
    logic       load_req;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       core_rx_clear;
    logic [7:0] core_prog_addr;
    logic       core_prog_rd_en;

    logic       rx_clear, core_rx_ready, prog_rd_en, prog_wr_en, core_rst, loading, overflow;
    logic [7:0] prog_addr;
    logic [2:0] prog_wr_data;
    logic [8:0] prog_len;

    logic       rx_clear_s, core_rx_ready_s, prog_rd_en_s, prog_wr_en_s, core_rst_s, loading_s, overflow_s;
    logic [1:0] prog_addr_s;
    logic [2:0] prog_wr_data_s;
    logic [2:0] prog_len_s;

    int checks = 0;
    int errors = 0;

    logic [2:0] mem [256];
    int wr_cnt = 0, wr_cnt_s = 0, clr_cnt = 0, dbl_clr = 0;
    logic prev_clr = 1'b0;

    always #5 clk = ~clk;

    bf_prog_loader #(.PROG_ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .rx_data(rx_data), .rx_ready(rx_ready),
        .rx_clear(rx_clear), .core_rx_ready(core_rx_ready), .core_rx_clear(core_rx_clear),
        .core_prog_addr(core_prog_addr), .core_prog_rd_en(core_prog_rd_en),
        .prog_addr(prog_addr), .prog_rd_en(prog_rd_en), .prog_wr_en(prog_wr_en),
        .prog_wr_data(prog_wr_data), .core_rst(core_rst), .prog_len(prog_len),
        .loading(loading), .overflow(overflow)
    );

    bf_prog_loader #(.PROG_ADDR_WIDTH(2)) dut_s (
        .clk(clk), .rst(rst), .load_req(load_req), .rx_data(rx_data), .rx_ready(rx_ready),
        .rx_clear(rx_clear_s), .core_rx_ready(core_rx_ready_s), .core_rx_clear(core_rx_clear),
        .core_prog_addr(core_prog_addr[1:0]), .core_prog_rd_en(core_prog_rd_en),
        .prog_addr(prog_addr_s), .prog_rd_en(prog_rd_en_s), .prog_wr_en(prog_wr_en_s),
        .prog_wr_data(prog_wr_data_s), .core_rst(core_rst_s), .prog_len(prog_len_s),
        .loading(loading_s), .overflow(overflow_s)
    );

    // Memory model and handshake monitor
    always @(negedge clk) begin
        if (prog_wr_en === 1'b1) begin
            mem[prog_addr] = prog_wr_data;
            wr_cnt++;
        end
        if (prog_wr_en_s === 1'b1) wr_cnt_s++;
        if (rx_clear === 1'b1) begin
            clr_cnt++;
            if (prev_clr) dbl_clr++;
        end
        prev_clr = (rx_clear === 1'b1);
    end

    task automatic clear_log();
        for (int i = 0; i < 256; i++) mem[i] = 3'bx;
        wr_cnt = 0; wr_cnt_s = 0; clr_cnt = 0; dbl_clr = 0;
    endtask

    // Offer one byte and wait (bounded) for the loader to take it
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        while (rx_clear !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rx_clear !== 1'b1) begin
            $display("FAIL send_byte_timeout: byte %h not taken, rx_clear=%b required 1", b, rx_clear);
            errors++;
        end
        rx_ready = 1'b0;
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; load_req = 1'b0; rx_ready = 1'b1; rx_data = 8'h2B;
        core_rx_clear = 1'b0; core_prog_addr = 8'h00; core_prog_rd_en = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (core_rst !== 1'b1) begin $display("FAIL reset_core_rst: got %b want 1", core_rst); errors++; end
        checks++; if (rx_clear !== 1'b0) begin $display("FAIL reset_rx_clear: got %b want 0", rx_clear); errors++; end
        checks++; if (prog_wr_en !== 1'b0) begin $display("FAIL reset_wr_en: got %b want 0", prog_wr_en); errors++; end
        checks++; if (prog_len !== 9'd0) begin $display("FAIL reset_prog_len: got %0d want 0", prog_len); errors++; end
        checks++; if (overflow !== 1'b0) begin $display("FAIL reset_overflow: got %b want 0", overflow); errors++; end
        checks++; if (core_rx_ready !== 1'b0) begin $display("FAIL reset_core_rx_ready: got %b want 0", core_rx_ready); errors++; end
        checks++; if (loading !== 1'b1) begin $display("FAIL reset_loading: got %b want 1", loading); errors++; end
        checks++; if (prog_addr !== 8'd0) begin $display("FAIL reset_prog_addr: got %h want 00", prog_addr); errors++; end
        rx_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] s [4];
        s = '{8'h2B, 8'h2D, 8'h5B, 8'h5D};
        clear_log();
        for (int i = 0; i < 4; i++) send_byte(s[i]);
        send_byte(8'h04);
        checks++; if (core_rst !== 1'b1) begin $display("FAIL basic_rst_at_eot: got %b want 1", core_rst); errors++; end
        @(negedge clk);
        checks++; if (core_rst !== 1'b1) begin $display("FAIL basic_rst_eot_plus1: got %b want 1", core_rst); errors++; end
        @(negedge clk);
        checks++; if (core_rst !== 1'b0) begin $display("FAIL basic_rst_eot_plus2: got %b want 0", core_rst); errors++; end
        checks++; if (wr_cnt !== 4) begin $display("FAIL basic_wr_cnt: got %0d want 4", wr_cnt); errors++; end
        checks++; if (mem[0] !== 3'd2 || mem[1] !== 3'd3 || mem[2] !== 3'd6 || mem[3] !== 3'd7) begin
            $display("FAIL basic_mem: got %0d %0d %0d %0d want 2 3 6 7", mem[0], mem[1], mem[2], mem[3]); errors++; end
        checks++; if (prog_len !== 9'd4) begin $display("FAIL basic_prog_len: got %0d want 4", prog_len); errors++; end
        checks++; if (loading !== 1'b0) begin $display("FAIL basic_loading: got %b want 0", loading); errors++; end
        core_prog_addr = 8'h5A; core_prog_rd_en = 1'b1;
        #1;
        checks++; if (prog_addr !== 8'h5A) begin $display("FAIL basic_addr_mux: got %h want 5a", prog_addr); errors++; end
        checks++; if (prog_rd_en !== 1'b1) begin $display("FAIL basic_rd_mux: got %b want 1", prog_rd_en); errors++; end
        core_prog_rd_en = 1'b0;
    endtask

    task automatic test_run_reload();
        rx_data = 8'h20; rx_ready = 1'b1;
        #1;
        checks++; if (core_rx_ready !== 1'b1) begin $display("FAIL run_core_rx_ready: got %b want 1", core_rx_ready); errors++; end
        core_rx_clear = 1'b1;
        #1;
        checks++; if (rx_clear !== 1'b1) begin $display("FAIL run_rx_clear_hi: got %b want 1", rx_clear); errors++; end
        core_rx_clear = 1'b0;
        #1;
        checks++; if (rx_clear !== 1'b0) begin $display("FAIL run_rx_clear_lo: got %b want 0", rx_clear); errors++; end
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        checks++; if (core_rst !== 1'b1) begin $display("FAIL reload_core_rst: got %b want 1", core_rst); errors++; end
        checks++; if (core_rx_ready !== 1'b0) begin $display("FAIL reload_core_rx_ready: got %b want 0", core_rx_ready); errors++; end
        checks++; if (prog_addr !== 8'h00) begin $display("FAIL reload_addr: got %h want 00", prog_addr); errors++; end
        checks++; if (prog_len !== 9'd4) begin $display("FAIL reload_prog_len_kept: got %0d want 4", prog_len); errors++; end
        rx_ready = 1'b0;
        @(negedge clk);
        load_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_filter();
        logic [7:0] s [5];
        s = '{8'h61, 8'h2B, 8'h20, 8'h0A, 8'h3E};
        clear_log();
        for (int i = 0; i < 5; i++) send_byte(s[i]);
        checks++; if (prog_len !== 9'd4) begin $display("FAIL filter_old_len: got %0d want 4", prog_len); errors++; end
        send_byte(8'h04);
        repeat (2) @(negedge clk);
        checks++; if (clr_cnt !== 6) begin $display("FAIL filter_clr_cnt: got %0d want 6", clr_cnt); errors++; end
        checks++; if (wr_cnt !== 2) begin $display("FAIL filter_wr_cnt: got %0d want 2", wr_cnt); errors++; end
        checks++; if (mem[0] !== 3'd2 || mem[1] !== 3'd0) begin
            $display("FAIL filter_mem: got %0d %0d want 2 0", mem[0], mem[1]); errors++; end
        checks++; if (prog_len !== 9'd2) begin $display("FAIL filter_prog_len: got %0d want 2", prog_len); errors++; end
    endtask

    task automatic test_overflow();
        pulse_load_req();
        clear_log();
        checks++; if (overflow_s !== 1'b0) begin $display("FAIL ovf_cleared: got %b want 0", overflow_s); errors++; end
        for (int i = 0; i < 4; i++) send_byte(8'h2B);
        checks++; if (overflow_s !== 1'b0) begin $display("FAIL ovf_at_depth: got %b want 0", overflow_s); errors++; end
        send_byte(8'h2B);
        checks++; if (overflow_s !== 1'b1) begin $display("FAIL ovf_set: got %b want 1", overflow_s); errors++; end
        send_byte(8'h04);
        repeat (2) @(negedge clk);
        checks++; if (wr_cnt_s !== 4) begin $display("FAIL ovf_wr_cnt: got %0d want 4", wr_cnt_s); errors++; end
        checks++; if (prog_len_s !== 3'd4) begin $display("FAIL ovf_prog_len: got %0d want 4", prog_len_s); errors++; end
        checks++; if (core_rst_s !== 1'b0) begin $display("FAIL ovf_released: got %b want 0", core_rst_s); errors++; end
        checks++; if (overflow_s !== 1'b1) begin $display("FAIL ovf_sticky: got %b want 1", overflow_s); errors++; end
        checks++; if (prog_len !== 9'd5 || overflow !== 1'b0) begin
            $display("FAIL ovf_big_inst: got len %0d ovf %b want 5 0", prog_len, overflow); errors++; end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s [4];
        int n;
        s = '{8'h2B, 8'h2D, 8'h2E, 8'h04};
        pulse_load_req();
        clear_log();
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_data = s[i];
            n = 0;
            @(negedge clk);
            while (rx_clear !== 1'b1 && n < 20) begin @(negedge clk); n++; end
            checks++;
            if (rx_clear !== 1'b1) begin $display("FAIL b2b_timeout: byte %0d rx_clear=%b want 1", i, rx_clear); errors++; end
        end
        rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (dbl_clr !== 0) begin $display("FAIL b2b_consec_clear: got %0d want 0", dbl_clr); errors++; end
        checks++; if (clr_cnt !== 4) begin $display("FAIL b2b_clr_cnt: got %0d want 4", clr_cnt); errors++; end
        checks++; if (wr_cnt !== 3) begin $display("FAIL b2b_wr_cnt: got %0d want 3", wr_cnt); errors++; end
        checks++; if (mem[0] !== 3'd2 || mem[1] !== 3'd3 || mem[2] !== 3'd4) begin
            $display("FAIL b2b_mem: got %0d %0d %0d want 2 3 4", mem[0], mem[1], mem[2]); errors++; end
        checks++; if (prog_len !== 9'd3) begin $display("FAIL b2b_prog_len: got %0d want 3", prog_len); errors++; end
    endtask

    task automatic test_reset_mid_load();
        pulse_load_req();
        clear_log();
        send_byte(8'h2B);
        send_byte(8'h2D);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (mem[0] !== 3'd2 || mem[1] !== 3'd3) begin
            $display("FAIL midrst_partial: got %0d %0d want 2 3", mem[0], mem[1]); errors++; end
        checks++; if (prog_len !== 9'd0) begin $display("FAIL midrst_prog_len: got %0d want 0", prog_len); errors++; end
        checks++; if (core_rst !== 1'b1) begin $display("FAIL midrst_core_rst: got %b want 1", core_rst); errors++; end
        checks++; if (loading !== 1'b1) begin $display("FAIL midrst_loading: got %b want 1", loading); errors++; end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (prog_addr !== 8'h00) begin $display("FAIL midrst_addr: got %h want 00", prog_addr); errors++; end
        clear_log();
        send_byte(8'h5D);
        send_byte(8'h5B);
        send_byte(8'h04);
        repeat (2) @(negedge clk);
        checks++; if (mem[0] !== 3'd7 || mem[1] !== 3'd6) begin
            $display("FAIL midrst_reload_mem: got %0d %0d want 7 6", mem[0], mem[1]); errors++; end
        checks++; if (prog_len !== 9'd2) begin $display("FAIL midrst_reload_len: got %0d want 2", prog_len); errors++; end
        checks++; if (core_rst !== 1'b0) begin $display("FAIL midrst_released: got %b want 0", core_rst); errors++; end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_run_reload();
        test_filter();
        test_overflow();
        test_back_to_back();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bf_prog_loader.md
Name: bf_prog_loader

Overview:
- Boot-time sequencer and arbiter for the brainfuck core's program memory and UART receive channel.
- After reset, or on request, it holds the core in reset and owns the UART RX stream. It decodes incoming ASCII brainfuck characters into 3-bit opcodes and writes them sequentially into a writable program memory (single-port RAM in loader builds).
- On an end-of-transmission byte it hands program memory and UART RX back to the core and releases the core from reset.
- Sits at top level between uart, program memory and brainfuck_core.

Parameters:
- PROG_ADDR_WIDTH, 8, program memory address width; depth = 2**PROG_ADDR_WIDTH.
- PROG_DATA_WIDTH, 3, opcode width.
- DATA_WIDTH, 8, UART byte width.
- EOT_CHAR, 8'h04, byte that terminates a load.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- load_req  in  1  level; a rising edge while in RUN starts a reload.
- rx_data  in  DATA_WIDTH  byte from uart output_axis_tdata.
- rx_ready  in  1  uart output_axis_tvalid.
- rx_clear  out  1  to uart output_axis_tready.
- core_rx_ready  out  1  rx_ready as seen by the core.
- core_rx_clear  in  1  core's rx_clear.
- core_prog_addr  in  PROG_ADDR_WIDTH  core program address.
- core_prog_rd_en  in  1  core program read enable.
- prog_addr  out  PROG_ADDR_WIDTH  to program memory.
- prog_rd_en  out  1  to program memory.
- prog_wr_en  out  1  to program memory.
- prog_wr_data  out  PROG_DATA_WIDTH  opcode to program memory.
- core_rst  out  1  active-high reset to brainfuck_core.
- prog_len  out  PROG_ADDR_WIDTH+1  instruction count of the last completed load.
- loading  out  1  high in LOAD_WAIT and LOAD_ACK.
- overflow  out  1  sticky; set when a load exceeds program memory depth.

Behaviour:
- States: LOAD_WAIT, LOAD_ACK, RELEASE, RUN.
- Reset (rst=0 at a clk edge):
  - state=LOAD_WAIT, wr_ptr=0, prog_len=0, overflow=0.
  - core_rst=1, rx_clear=0, prog_wr_en=0, load_req edge detector cleared.
- Arbitration, combinational on state:
  - RUN: prog_addr=core_prog_addr, prog_rd_en=core_prog_rd_en, rx_clear=core_clear path, core_rx_ready=rx_ready.
  - Otherwise: prog_addr=wr_ptr[PROG_ADDR_WIDTH-1:0], prog_rd_en=0, core_rx_ready=0, core_rx_clear ignored.
- LOAD_WAIT, when rx_ready=1:
  - Registered rx_clear=1 for exactly one cycle; next state LOAD_ACK.
  - Byte is one of > < + - . , [ ]:
    - If wr_ptr < depth: prog_wr_en=1 that cycle, prog_wr_data = opcode from the shared constants, wr_ptr++.
    - If wr_ptr = depth: no write, overflow=1.
  - Byte = EOT_CHAR: no write; prog_len<=wr_ptr; next state RELEASE instead of LOAD_ACK. rx_clear is still pulsed.
  - Any other byte: consumed and discarded (comments, whitespace).
- LOAD_ACK: one cycle. rx_clear=0, prog_wr_en=0, so rx_ready has deasserted before it is resampled. Next state LOAD_WAIT.
- Write timing: prog_wr_en, prog_wr_data and prog_addr are registered and valid in the same cycle rx_clear is high.
- RELEASE: one cycle with core_rst=1 so the core's first fetch sees stable memory. Then RUN with core_rst=0.
- RUN: core_rst=0. A load_req rising edge (registered edge detect) moves to LOAD_WAIT:
  - wr_ptr=0 and overflow=0 on entry; core_rst=1 from the next cycle.
  - prog_len holds its old value until the new EOT.
- A load_req edge during a load is ignored.
- An empty load (EOT first) gives prog_len=0; the core is still released.
- rst asserted mid-load aborts the load. Partially written memory is not cleared, and prog_len returns to 0.
- Program memory contents beyond prog_len are unspecified.

Decomposition:
- Opcode encoding (> 0, < 1, + 2, - 3, . 4, , 5, [ 6, ] 7), EOT_CHAR and the loader state enum go in the shared brainfuck_constants package.
- One sub-module, bf_char_decode: combinational ASCII to {valid, opcode}.
- The state machine, pointer and muxing stay in bf_prog_loader.

Test Plan:
- Reset, then send "+-[]" followed by 0x04:
  - Writes opcodes 2,3,6,7 at addresses 0..3.
  - prog_len=4.
  - core_rst falls exactly 2 cycles after the EOT rx_clear.
  - prog_addr then follows core_prog_addr.
- Send "a+ \n>" followed by 0x04:
  - Only 2 writes: addr0=2, addr1=0.
  - prog_len=2.
  - rx_clear pulses 6 times, one per byte.
- With PROG_ADDR_WIDTH=2, send "+++++" followed by 0x04:
  - 4 writes.
  - overflow=1.
  - prog_len=4.
  - Core released.
- In RUN with core reading UART, core_rx_clear drives rx_clear. Then pulse load_req:
  - core_rst=1 and core_rx_ready=0 next cycle.
  - A new load starts at address 0; the old prog_len is kept until EOT.
- Hold rx_ready high for 3 bytes back-to-back:
  - rx_clear is never high on consecutive cycles.
  - One write per byte, no duplicates.
- Assert rst after 2 of 4 characters:
  - State returns to LOAD_WAIT with prog_len=0 and core_rst=1.
  - The following load writes from address 0.
